// File: rtl/game_screen_ctrl_if.sv
// Bundles the button, pixel index, coordinate and screen-select signals of game_screen_ctrl.
// master drives the button/pixel index; slave is the controller that answers with coordinates and events.
interface game_screen_ctrl_if;
    logic        btn_c;
    logic [12:0] pixel_index;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [2:0]  screen_sel;
    logic        press_pulse;
    logic        hold_pulse;
    logic        hold_active;

    modport master (
        output btn_c, pixel_index,
        input  x, y, screen_sel, press_pulse, hold_pulse, hold_active
    );

    modport slave (
        input  btn_c, pixel_index,
        output x, y, screen_sel, press_pulse, hold_pulse, hold_active
    );
endinterface

// File: rtl/game_screen_ctrl.sv
// Button debounce + PRESS/HOLD classifier stepping the screen index, plus pixel_index -> (x,y); coords 1 cycle, button 2+DEBOUNCE_CYCLES.
// No backpressure (all outputs are free-running registers). Define GAME_SCREEN_NOWRAP_EN to saturate screen_sel instead of wrapping.
module game_screen_ctrl #(
    parameter int DEBOUNCE_CYCLES = 62500,
    parameter int HOLD_CYCLES     = 6250000,
    parameter int NUM_SCREENS     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    game_screen_ctrl_if.slave  bus
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    SEL_MAX  = 3'(NUM_SCREENS - 1);
    localparam logic [12:0]   COLS     = 13'd96;
    localparam logic [12:0]   NPIX     = 13'd6144;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    logic [1:0]    sync_q;
    logic          btn_sync;
    logic          btn_db;
    logic          btn_db_nxt;
    logic [DW-1:0] db_cnt;
    logic [DW-1:0] db_cnt_nxt;

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_cnt_nxt;
    logic          press_q;
    logic          press_nxt;
    logic          hold_q;
    logic          hold_nxt;
    logic          hold_active_q;
    logic          hold_active_nxt;
    logic [2:0]    sel_q;
    logic [2:0]    sel_nxt;

    logic [12:0]   rem;
    logic [5:0]    quo;
    logic [6:0]    x_q;
    logic [6:0]    x_nxt;
    logic [5:0]    y_q;
    logic [5:0]    y_nxt;

    assign btn_sync = sync_q[1];

    // Two-flop synchroniser for the asynchronous pushbutton.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.btn_c};
        end
    end

    always_comb begin
        btn_db_nxt = btn_db;
        db_cnt_nxt = '0;
        if (btn_sync != btn_db) begin
            if (db_cnt == DB_MAX) begin
                btn_db_nxt = ~btn_db;
            end else begin
                db_cnt_nxt = db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else begin
            btn_db <= btn_db_nxt;
            db_cnt <= db_cnt_nxt;
        end
    end

    // The classifier follows the debounced level as it is being registered, so its
    // transitions share the edge on which btn_db itself changes.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        press_nxt    = 1'b0;
        hold_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (btn_db_nxt) begin
                    state_nxt    = PRESSED;
                    hold_cnt_nxt = '0;
                end
            end
            PRESSED: begin
                if (!btn_db_nxt) begin
                    press_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (hold_cnt == HOLD_MAX) begin
                    hold_nxt  = 1'b1;
                    state_nxt = HELD;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_db_nxt) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        hold_active_nxt = (state_nxt == HELD);
    end

    always_comb begin
        sel_nxt = sel_q;
        if (press_nxt) begin
`ifdef GAME_SCREEN_NOWRAP_EN
            if (sel_q != SEL_MAX) begin
                sel_nxt = sel_q + 3'd1;
            end
`else
            if (sel_q == SEL_MAX) begin
                sel_nxt = 3'd0;
            end else begin
                sel_nxt = sel_q + 3'd1;
            end
`endif
        end else if (hold_nxt) begin
            sel_nxt = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            press_q       <= 1'b0;
            hold_q        <= 1'b0;
            hold_active_q <= 1'b0;
            sel_q         <= 3'd0;
        end else begin
            state         <= state_nxt;
            hold_cnt      <= hold_cnt_nxt;
            press_q       <= press_nxt;
            hold_q        <= hold_nxt;
            hold_active_q <= hold_active_nxt;
            sel_q         <= sel_nxt;
        end
    end

    // Restoring division by 96: six compare-and-subtract steps cover rows 0..63.
    always_comb begin
        rem = bus.pixel_index;
        quo = 6'd0;
        for (int i = 5; i >= 0; i--) begin
            if (rem >= (COLS << i)) begin
                rem    = rem - (COLS << i);
                quo[i] = 1'b1;
            end
        end
        if (bus.pixel_index >= NPIX) begin
            x_nxt = 7'd0;
            y_nxt = 6'd0;
        end else begin
            x_nxt = rem[6:0];
            y_nxt = quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= 7'd0;
            y_q <= 6'd0;
        end else begin
            x_q <= x_nxt;
            y_q <= y_nxt;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.screen_sel  = sel_q;
    assign bus.press_pulse = press_q;
    assign bus.hold_pulse  = hold_q;
    assign bus.hold_active = hold_active_q;

endmodule
